scan_config_loader: RTL and testbench
=====================================

# scan_config_loader

Scan-chain configuration master for the routing fabric. It accepts the configuration bitstream as host words over a valid/ready handshake and serializes it onto the `scan_in`/`scan_en`/`scan_clk` chain that threads the channel control registers. The `scan_out` pin returns from the far end of that chain into this block. An optional verify pass recirculates the chain and checks the loaded contents by parity without disturbing them.

## Interface
Parameters:
- `CHAIN_LEN`, 20: total bits in the chain (one vertical plus one horizontal channel = 8 + 12).
- `WORD_W`, 8: host word width.
- `CLK_DIV`, 2: `clk` cycles per `scan_clk` phase; must be ≥ 1.

Ports:
- `clk`, input, 1: sole clock.
- `rst_n`, input, 1: reset, asynchronous, active-low.
- `start`, input, 1: begin a load when IDLE.
- `verify_en`, input, 1: sampled with `start`; enables the verify pass.
- `cfg_data`, input, `WORD_W`: bitstream word, MSB sent first.
- `cfg_valid`, input, 1: `cfg_data` is valid.
- `cfg_ready`, output, 1: word accepted when `cfg_valid && cfg_ready`.
- `busy`, output, 1: high from the cycle after an accepted `start` until `done`.
- `done`, output, 1: one-cycle pulse at the end of an operation.
- `verify_err`, output, 1: parity mismatch from the last verify; held until the next `start`.
- `scan_in`, output, 1: serial data to the chain head.
- `scan_en`, output, 1: chain shift enable.
- `scan_clk`, output, 1: generated chain clock; idles low.
- `scan_out`, input, 1: chain tail.

## Operation
- All outputs are registered. Reset value of every output is 0.
- States and transitions:
  - IDLE: `start` → LOAD, clear `verify_err`.
  - LOAD: after `CHAIN_LEN` rising edges of `scan_clk` → VERIFY if `verify_en` was latched, else DONE.
  - VERIFY: after `CHAIN_LEN` rising edges → DONE.
  - DONE: one cycle, pulse `done`, then → IDLE.
- Word buffer is one entry. `cfg_ready` is 1 only in LOAD while the buffer is empty and fewer than ceil(`CHAIN_LEN`/`WORD_W`) words have been accepted. `cfg_ready` is 0 in IDLE, VERIFY and DONE.
- Bits are shifted MSB-first. The first bit sent ends deepest in the chain, at the MSB of the last register.
- Final-word bits beyond `CHAIN_LEN` are the LSBs of that word and are discarded without being shifted.
- Bit period is 2·`CLK_DIV` clks: `CLK_DIV` low, then `CLK_DIV` high.
- `scan_in` and `scan_en` change only on the `clk` edge that drives `scan_clk` low, or at state entry while `scan_clk` is low. This guarantees `CLK_DIV` clks of setup before each rising edge.
- Underflow: if no bit is available at the end of a low phase, `scan_clk` stays low until a word arrives. No extra edges are produced.
- `scan_en` is 1 throughout LOAD and VERIFY, including stalls, and is 0 otherwise.
- `load_par` is the XOR of all `CHAIN_LEN` bits sent.
- VERIFY pass:
  - At each low-going update, `scan_in <= scan_out` and `rd_par ^= scan_out`.
  - After `CHAIN_LEN` edges the chain holds its original contents.
  - At exit, `verify_err <= rd_par ^ load_par`.
- `start` is ignored outside IDLE. `cfg_valid` is ignored when `cfg_ready` is 0.
- No abort input exists; a reset is the only way to abandon an operation.

## Timing
- `start` at cycle t → `busy`, `scan_en` = 1 and `cfg_ready` = 1 at t+1.
- First `scan_clk` rise occurs `CLK_DIV` clks after the first bit is loaded into `scan_in`.
- Unstalled LOAD lasts `CHAIN_LEN`·2·`CLK_DIV` clks from the first word acceptance to the last falling edge. VERIFY adds the same amount again.
- `done` is high for exactly 1 cycle. `busy` drops in the same cycle `done` rises.
- Final `scan_clk` falling edge precedes `scan_en` deassertion. `scan_en` and `scan_clk` are never high together with `scan_en` falling.
- Reset mid-operation:
  - All outputs go to 0 asynchronously; the FSM goes to IDLE; counters and parity clear.
  - Chain contents are undefined and a full reload is required.
  - `scan_clk` never glitches high during reset.
- `scan_out` is sampled at the low-going edge, which comes `CLK_DIV` clks after the chain's rising edge. Chain clock-to-out must be under `CLK_DIV` clks.

## Test plan
- **Basic load:** `CHAIN_LEN`=20, `WORD_W`=8, `CLK_DIV`=2, `verify_en`=0, words 0xA5, 0x3C, 0xF0.
  - Exactly 20 `scan_clk` rises.
  - `scan_in` sequence 1010_0101_0011_1100_1111.
  - A 5×4-bit chain model holds the expected bits.
  - 3 handshakes; `done` pulses once; `verify_err`=0.
- **Verify pass:** same stream with `verify_en`=1 on a fault-free chain model.
  - 40 rises total; `verify_err`=0.
  - Chain contents after the pass are identical to the contents after the load.
- **Fault detection:** verify pass with one chain bit stuck-at-0 where a 1 was loaded → `verify_err`=1 after `done`.
- **Underflow stall:** `cfg_valid` deasserted for 11 cycles between words 1 and 2.
  - `scan_clk` is held low during the gap.
  - Still exactly 20 rises and the same final contents.
  - `scan_en` stays 1 throughout.
- **Reset mid-load:** drop `rst_n` after 7 rises.
  - All outputs are 0 in the same cycle.
  - A new `start` with 0x5A, 0xC3, 0x0F loads correctly with 20 rises.
- **Ignored inputs:**
  - `start` pulsed during LOAD → no restart and the edge count is unaffected.
  - `cfg_valid`=1 in IDLE → `cfg_ready`=0 and no word is consumed.

Source files
------------

// File: rtl/scan_config_loader.sv
// Scan-chain configuration master: serializes host words MSB-first onto the
// scan chain and optionally recirculates the chain to check it by parity.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | waiting for start; scan_en low, scan_clk low
// S_LOAD   | accepting words and shifting CHAIN_LEN bits into the chain
// S_VERIFY | recirculating scan_out to scan_in for CHAIN_LEN bits
// S_DONE   | single-cycle done pulse, then back to idle
module scan_config_loader #(
    parameter int CHAIN_LEN = 20,
    parameter int WORD_W    = 8,
    parameter int CLK_DIV   = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              verify_en,
    input  logic [WORD_W-1:0] cfg_data,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    output logic              busy,
    output logic              done,
    output logic              verify_err,
    output logic              scan_in,
    output logic              scan_en,
    output logic              scan_clk,
    input  logic              scan_out
);

    localparam int NWORDS = (CHAIN_LEN + WORD_W - 1) / WORD_W;
    localparam int CW     = $clog2(WORD_W + 1);
    localparam int WW     = $clog2(NWORDS + 1);
    localparam int EW     = $clog2(CHAIN_LEN + 1);
    localparam int DW     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [WW-1:0] NWORDS_C  = WW'(NWORDS);
    localparam logic [EW-1:0] EDGE_INIT = EW'(CHAIN_LEN);
    localparam logic [DW-1:0] DIV_MAX   = DW'(CLK_DIV - 1);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_VERIFY, S_DONE} state_t;

    state_t            state_q, state_d;
    logic              vfy_q, vfy_d;
    logic [WORD_W-1:0] buf_q, buf_d;
    logic [CW-1:0]     bcnt_q, bcnt_d;
    logic [WW-1:0]     words_q, words_d;
    logic [EW-1:0]     edge_q, edge_d;
    logic [DW-1:0]     div_q, div_d;
    logic              have_q, have_d;
    logic              sclk_q, sclk_d;
    logic              sin_q, sin_d;
    logic              sen_q, sen_d;
    logic              lpar_q, lpar_d;
    logic              rpar_q, rpar_d;
    logic              verr_q, verr_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              rdy_q, rdy_d;
    logic              hs, take, direct;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            vfy_q   <= 1'b0;
            buf_q   <= '0;
            bcnt_q  <= '0;
            words_q <= '0;
            edge_q  <= '0;
            div_q   <= '0;
            have_q  <= 1'b0;
            sclk_q  <= 1'b0;
            sin_q   <= 1'b0;
            sen_q   <= 1'b0;
            lpar_q  <= 1'b0;
            rpar_q  <= 1'b0;
            verr_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            vfy_q   <= vfy_d;
            buf_q   <= buf_d;
            bcnt_q  <= bcnt_d;
            words_q <= words_d;
            edge_q  <= edge_d;
            div_q   <= div_d;
            have_q  <= have_d;
            sclk_q  <= sclk_d;
            sin_q   <= sin_d;
            sen_q   <= sen_d;
            lpar_q  <= lpar_d;
            rpar_q  <= rpar_d;
            verr_q  <= verr_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            rdy_q   <= rdy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        vfy_d   = vfy_q;
        buf_d   = buf_q;
        bcnt_d  = bcnt_q;
        words_d = words_q;
        edge_d  = edge_q;
        div_d   = div_q;
        have_d  = have_q;
        sclk_d  = sclk_q;
        sin_d   = sin_q;
        sen_d   = sen_q;
        lpar_d  = lpar_q;
        rpar_d  = rpar_q;
        verr_d  = verr_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        take    = 1'b0;
        direct  = 1'b0;
        hs      = cfg_valid && rdy_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_LOAD;
                    vfy_d   = verify_en;
                    verr_d  = 1'b0;
                    buf_d   = '0;
                    bcnt_d  = '0;
                    words_d = '0;
                    edge_d  = EDGE_INIT;
                    div_d   = '0;
                    have_d  = 1'b0;
                    sin_d   = 1'b0;
                    sen_d   = 1'b1;
                    lpar_d  = 1'b0;
                    rpar_d  = 1'b0;
                    busy_d  = 1'b1;
                end
            end
            S_LOAD, S_VERIFY: begin
                if (sclk_q) begin
                    if (div_q == '0) begin
                        sclk_d = 1'b0;
                        if (edge_q != '0) begin
                            take = 1'b1;
                        end else if (state_q == S_LOAD && vfy_q) begin
                            state_d = S_VERIFY;
                            edge_d  = EDGE_INIT;
                            take    = 1'b1;
                        end else begin
                            have_d = 1'b0;
                        end
                    end else begin
                        div_d = div_q - DW'(1);
                    end
                end else if (edge_q == '0) begin
                    // exit one cycle after the last falling edge so scan_en drops strictly later
                    state_d = S_DONE;
                    sen_d   = 1'b0;
                    sin_d   = 1'b0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    have_d  = 1'b0;
                    if (state_q == S_VERIFY) verr_d = rpar_q ^ lpar_q;
                end else if (have_q) begin
                    if (div_q == '0) begin
                        sclk_d = 1'b1;
                        edge_d = edge_q - EW'(1);
                        div_d  = DIV_MAX;
                    end else begin
                        div_d = div_q - DW'(1);
                    end
                end else begin
                    take = 1'b1;
                end

                if (take) begin
                    have_d = 1'b1;
                    div_d  = DIV_MAX;
                    if (state_d == S_VERIFY) begin
                        sin_d  = scan_out;
                        rpar_d = rpar_q ^ scan_out;
                    end else if (bcnt_q != '0) begin
                        sin_d  = buf_q[WORD_W-1];
                        buf_d  = buf_q << 1;
                        bcnt_d = bcnt_q - CW'(1);
                    end else if (hs) begin
                        // buffer empty and a word is arriving: its MSB goes straight out
                        direct = 1'b1;
                        sin_d  = cfg_data[WORD_W-1];
                        buf_d  = cfg_data << 1;
                        bcnt_d = CW'(WORD_W - 1);
                    end else begin
                        have_d = 1'b0;
                    end
                    if (state_d == S_LOAD && have_d) begin
                        lpar_d = lpar_q ^ sin_d;
                        if (edge_q == EW'(1)) bcnt_d = '0;
                    end
                end

                if (hs) begin
                    words_d = words_q + WW'(1);
                    if (!direct) begin
                        buf_d  = cfg_data;
                        bcnt_d = CW'(WORD_W);
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        rdy_d = (state_d == S_LOAD) && (bcnt_d == '0) && (words_d < NWORDS_C);
    end

    assign cfg_ready  = rdy_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign verify_err = verr_q;
    assign scan_in    = sin_q;
    assign scan_en    = sen_q;
    assign scan_clk   = sclk_q;

endmodule

// File: tb/tb_scan_config_loader.sv
// Directed bench for scan_config_loader with a 20-bit chain model on scan_clk.
module tb_scan_config_loader;

    localparam int CLK_DIV = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       verify_en = 1'b0;
    logic [7:0] cfg_data = 8'h00;
    logic       cfg_valid = 1'b0;
    logic       cfg_ready, busy, done, verify_err, scan_in, scan_en, scan_clk, scan_out;

    int total = 0;
    int bad = 0;

    scan_config_loader #(.CHAIN_LEN(20), .WORD_W(8), .CLK_DIV(CLK_DIV)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .verify_en(verify_en),
        .cfg_data(cfg_data), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .busy(busy), .done(done), .verify_err(verify_err),
        .scan_in(scan_in), .scan_en(scan_en), .scan_clk(scan_clk), .scan_out(scan_out)
    );

    always #5 clk = ~clk;

    // chain model: bit 19 is the tail (MSB of the last 4-bit register)
    logic [19:0] chain = '0;
    logic [39:0] sent = '0;
    logic [19:0] chain_eff;
    int          rises = 0;
    int          rise0 = 0;
    bit          fault_arm = 1'b0;

    assign chain_eff = (fault_arm && (rises - rise0 >= 20)) ? (chain & ~20'h00001) : chain;
    assign scan_out  = chain_eff[19];

    always @(posedge scan_clk) begin
        chain <= {chain_eff[18:0], scan_in};
        sent  <= {sent[38:0], scan_in};
        rises <= rises + 1;
    end

    int   hs_cnt = 0;
    int   done_cnt = 0;
    int   viol = 0;
    int   sin_age = 0;
    logic p_sclk = 1'b0, p_sen = 1'b0, p_sin = 1'b0, p_rst = 1'b0;

    always @(posedge clk) if (cfg_valid && cfg_ready) hs_cnt <= hs_cnt + 1;

    always @(negedge clk) begin
        if (done) done_cnt <= done_cnt + 1;
        if (rst_n && p_rst) begin
            if ((done && busy) || (scan_clk && !scan_en) || (scan_clk && scan_in != p_sin) ||
                (p_sen && !scan_en && p_sclk) ||
                (scan_clk && !p_sclk && !((scan_in == p_sin) && (sin_age + 1 >= CLK_DIV))))
                viol <= viol + 1;
        end
        sin_age <= (scan_in != p_sin) ? 0 : sin_age + 1;
        p_sclk  <= scan_clk;
        p_sen   <= scan_en;
        p_sin   <= scan_in;
        p_rst   <= rst_n;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] w, input string nm);
        int  n;
        bit  ok;
        ok = 1'b0;
        cfg_data  = w;
        cfg_valid = 1'b1;
        for (n = 0; n < 300; n++) begin
            if (cfg_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        cfg_valid = 1'b0;
        chk({nm, ".handshake"}, ok, 1'b1);
    endtask

    task automatic do_op(input logic [7:0] w0, input logic [7:0] w1, input logic [7:0] w2,
                         input bit vfy, input int gap, input bit pulse_start, input bit fault,
                         input logic [19:0] exp_chain, input bit exp_err, input string nm);
        int r0, h0, d0, v0, n, gb;
        @(negedge clk);
        fault_arm = fault;
        rise0 = rises;
        r0 = rises; h0 = hs_cnt; d0 = done_cnt; v0 = viol;
        start = 1'b1; verify_en = vfy;
        @(negedge clk);
        start = 1'b0; verify_en = 1'b0;
        chk({nm, ".busy_t1"}, busy, 1'b1);
        chk({nm, ".scan_en_t1"}, scan_en, 1'b1);
        chk({nm, ".ready_t1"}, cfg_ready, 1'b1);
        chk({nm, ".err_clr"}, verify_err, 1'b0);
        send(w0, nm);
        if (pulse_start) begin
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        if (gap > 0) begin
            for (n = 0; n < 200 && !cfg_ready; n++) @(negedge clk);
            gb = 0;
            repeat (gap) begin
                @(negedge clk);
                if (!scan_en) gb++;
            end
            chk({nm, ".gap_en"}, gb, 0);
            chk({nm, ".gap_sclk_low"}, scan_clk, 1'b0);
            chk({nm, ".gap_rises"}, rises - r0, 8);
        end
        send(w1, nm);
        send(w2, nm);
        for (n = 0; n < 1000 && !done; n++) @(negedge clk);
        chk({nm, ".done_seen"}, done, 1'b1);
        chk({nm, ".busy_at_done"}, busy, 1'b0);
        @(negedge clk);
        chk({nm, ".done_width"}, done, 1'b0);
        chk({nm, ".done_count"}, done_cnt - d0, 1);
        chk({nm, ".rises"}, rises - r0, vfy ? 40 : 20);
        chk({nm, ".handshakes"}, hs_cnt - h0, 3);
        chk({nm, ".verify_err"}, verify_err, exp_err);
        chk({nm, ".scan_en_off"}, scan_en, 1'b0);
        chk({nm, ".timing"}, viol - v0, 0);
        if (vfy) chk({nm, ".load_seq"}, sent[39:20], exp_chain);
        if (!fault) begin
            chk({nm, ".seq"}, sent[19:0], exp_chain);
            chk({nm, ".chain"}, chain, exp_chain);
        end
    endtask

    initial begin
        int r0, n, rb, h0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset.outputs", {cfg_ready, busy, done, verify_err, scan_in, scan_en, scan_clk}, 7'b0);
        rst_n = 1'b1;
        @(negedge clk);

        h0 = hs_cnt; rb = 0;
        cfg_data = 8'hFF; cfg_valid = 1'b1;
        repeat (5) begin
            @(negedge clk);
            if (cfg_ready) rb++;
        end
        cfg_valid = 1'b0;
        chk("idle.ready", rb, 0);
        chk("idle.no_consume", hs_cnt - h0, 0);

        do_op(8'hA5, 8'h3C, 8'hF0, 1'b0, 0, 1'b0, 1'b0, 20'hA53CF, 1'b0, "basic");
        do_op(8'hA5, 8'h3C, 8'hF0, 1'b1, 0, 1'b0, 1'b0, 20'hA53CF, 1'b0, "verify");
        do_op(8'hA5, 8'h3C, 8'hF0, 1'b1, 0, 1'b0, 1'b1, 20'hA53CF, 1'b1, "fault");
        repeat (5) @(negedge clk);
        chk("fault.err_hold", verify_err, 1'b1);
        do_op(8'hA5, 8'h3C, 8'hF0, 1'b0, 11, 1'b0, 1'b0, 20'hA53CF, 1'b0, "stall");
        do_op(8'hA5, 8'h3C, 8'hF0, 1'b0, 0, 1'b1, 1'b0, 20'hA53CF, 1'b0, "ign_start");

        @(negedge clk);
        r0 = rises;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        send(8'h11, "rst");
        for (n = 0; n < 300 && (rises - r0) < 7; n++) @(negedge clk);
        chk("rst.rises_before", rises - r0, 7);
        chk("rst.sclk_high", scan_clk, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("rst.outputs", {cfg_ready, busy, done, verify_err, scan_in, scan_en, scan_clk}, 7'b0);
        @(negedge clk);
        rst_n = 1'b1;
        do_op(8'h5A, 8'hC3, 8'h0F, 1'b0, 0, 1'b0, 1'b0, 20'h5AC30, 1'b0, "reload");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
